// File: rtl/display_scanner_pkg.sv
// rtl/display_scanner_pkg.sv - shared constants and helpers for the seven-segment scanner
package display_scanner_pkg;

  localparam int NIBBLE_W = 4;
  localparam logic DIGIT_OFF = 1'b1;
  localparam logic DIGIT_ON = 1'b0;
  localparam logic [3:0] INV_ZERO = 4'hF;

  // Never returns 0 so that counters of depth 1 still get a one-bit register.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/display_scanner_prescaler.sv
// rtl/display_scanner_prescaler.sv - slot-length prescaler with terminal-count pulse
module refresh_prescaler
  import display_scanner_pkg::*;
#(
  parameter int DIV = 50000,
  parameter int CNT_W = clog2(DIV)
) (
  input  logic             CLK,
  input  logic             RESET_N,
  output logic [CNT_W-1:0] count,
  output logic             tc
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    tc      = (count_q == CNT_W'(DIV - 1));
    count_d = tc ? '0 : count_q + 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) count_q <= '0;
    else          count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/display_scanner.sv
// rtl/display_scanner.sv - time-multiplexed common-anode digit scanner with tear-free commit
module display_scanner
  import display_scanner_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int DEAD_CYCLES = 2
) (
  input  logic                           CLK,
  input  logic                           RESET_N,
  input  logic                           LOAD,
  input  logic [NIBBLE_W*NUM_DIGITS-1:0] VALUE_IN,
  input  logic                           LZ_BLANK,
  input  logic [NUM_DIGITS-1:0]          BLANK_IN,
  output logic [NIBBLE_W-1:0]            DIGIT_OUT,
  output logic [NUM_DIGITS-1:0]          DIGIT_EN_N,
  output logic                           PENDING,
  output logic                           FRAME_TICK
);

  localparam int CNT_W = clog2(REFRESH_DIV);
  localparam int IDX_W = clog2(NUM_DIGITS);
  localparam int VAL_W = NIBBLE_W * NUM_DIGITS;

  logic [CNT_W-1:0]      count, cnt_nxt;
  logic                  tc, wrap, zero_run;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [VAL_W-1:0]      display_q, display_d, shadow_q, shadow_d;
  logic                  pending_q, pending_d, frame_tick_q, frame_tick_d;
  logic [NIBBLE_W-1:0]   digit_out_q, digit_out_d;
  logic [NUM_DIGITS-1:0] digit_en_n_q, digit_en_n_d, lz_mask, blank;

  refresh_prescaler #(.DIV(REFRESH_DIV), .CNT_W(CNT_W)) u_prescaler (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .count   (count),
    .tc      (tc)
  );

  always_comb begin
    cnt_nxt = tc ? '0 : count + 1'b1;
    wrap    = tc && (idx_q == IDX_W'(NUM_DIGITS - 1));
    idx_d   = idx_q;
    if (tc) idx_d = wrap ? '0 : idx_q + 1'b1;
  end

  // A LOAD coinciding with the frame boundary goes straight to the display.
  always_comb begin
    display_d    = display_q;
    shadow_d     = LOAD ? VALUE_IN : shadow_q;
    pending_d    = pending_q;
    frame_tick_d = wrap;
    if (wrap) begin
      if (LOAD)           display_d = VALUE_IN;
      else if (pending_q) display_d = shadow_q;
      pending_d = 1'b0;
    end else if (LOAD) begin
      pending_d = 1'b1;
    end
  end

  // Scan from the most significant digit down; zero_run stays set while all nibbles seen are zero.
  always_comb begin
    zero_run = 1'b1;
    lz_mask  = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_run   = zero_run && (display_d[k*NIBBLE_W +: NIBBLE_W] == '0);
      lz_mask[k] = zero_run && (k != 0);
    end
    blank = BLANK_IN | (LZ_BLANK ? lz_mask : '0);
  end

  always_comb begin
    digit_out_d  = ~display_d[idx_d*NIBBLE_W +: NIBBLE_W];
    digit_en_n_d = {NUM_DIGITS{DIGIT_OFF}};
    if ((32'(cnt_nxt) >= DEAD_CYCLES) && !blank[idx_d]) digit_en_n_d[idx_d] = DIGIT_ON;
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      idx_q        <= '0;
      display_q    <= '0;
      shadow_q     <= '0;
      pending_q    <= 1'b0;
      frame_tick_q <= 1'b0;
      digit_out_q  <= INV_ZERO;
      digit_en_n_q <= {NUM_DIGITS{DIGIT_OFF}};
    end else begin
      idx_q        <= idx_d;
      display_q    <= display_d;
      shadow_q     <= shadow_d;
      pending_q    <= pending_d;
      frame_tick_q <= frame_tick_d;
      digit_out_q  <= digit_out_d;
      digit_en_n_q <= digit_en_n_d;
    end
  end

  assign DIGIT_OUT  = digit_out_q;
  assign DIGIT_EN_N = digit_en_n_q;
  assign PENDING    = pending_q;
  assign FRAME_TICK = frame_tick_q;

endmodule

// File: tb/tb_display_scanner.sv
// tb/tb_display_scanner.sv - scoreboard bench for display_scanner against a time-based reference model
module tb_display_scanner;

  localparam int N    = 4;
  localparam int DIV  = 4;
  localparam int DEAD = 1;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        LOAD = 1'b0;
  logic [15:0] VALUE_IN = '0;
  logic        LZ_BLANK = 1'b0;
  logic [3:0]  BLANK_IN = '0;
  logic [3:0]  DIGIT_OUT;
  logic [3:0]  DIGIT_EN_N;
  logic        PENDING;
  logic        FRAME_TICK;

  display_scanner #(.NUM_DIGITS(N), .REFRESH_DIV(DIV), .DEAD_CYCLES(DEAD)) dut (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .LOAD       (LOAD),
    .VALUE_IN   (VALUE_IN),
    .LZ_BLANK   (LZ_BLANK),
    .BLANK_IN   (BLANK_IN),
    .DIGIT_OUT  (DIGIT_OUT),
    .DIGIT_EN_N (DIGIT_EN_N),
    .PENDING    (PENDING),
    .FRAME_TICK (FRAME_TICK)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0] dout;
    logic [3:0] en;
    logic       pend;
    logic       ft;
  } exp_t;

  exp_t exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  // Reference model: position in the scan is derived from cycles since reset.
  int          t = 0;
  logic [15:0] m_disp = '0;
  logic [15:0] m_shadow = '0;
  logic        m_pend = 1'b0;

  task automatic step(input logic rn, input logic ld, input logic [15:0] v,
                      input logic lz, input logic [3:0] bl);
    exp_t e;
    int cnt, slot;
    logic wrap, blanked;
    logic [15:0] sh;
    @(negedge CLK);
    RESET_N = rn; LOAD = ld; VALUE_IN = v; LZ_BLANK = lz; BLANK_IN = bl;
    if (!rn) begin
      t = 0; m_disp = '0; m_shadow = '0; m_pend = 1'b0;
      e.dout = 4'hF; e.en = 4'hF; e.pend = 1'b0; e.ft = 1'b0;
    end else begin
      t++;
      cnt  = t % DIV;
      slot = (t / DIV) % N;
      wrap = (t % (DIV * N)) == 0;
      if (wrap) begin
        m_disp = ld ? v : (m_pend ? m_shadow : m_disp);
        m_pend = 1'b0;
        if (ld) m_shadow = v;
      end else if (ld) begin
        m_shadow = v;
        m_pend = 1'b1;
      end
      sh = m_disp >> (4 * slot);
      blanked = bl[slot] || (lz && slot != 0 && sh == 16'h0);
      e.dout = ~sh[3:0];
      e.en = 4'hF;
      if (cnt >= DEAD && !blanked) e.en[slot] = 1'b0;
      e.pend = m_pend;
      e.ft = wrap;
    end
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n, input logic lz);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 16'h0, lz, 4'h0);
  endtask

  task automatic to_commit_edge(input logic lz);
    while (((t + 1) % (DIV * N)) != 0) step(1'b1, 1'b0, 16'h0, lz, 4'h0);
  endtask

  always @(posedge CLK) begin
    exp_t e;
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      vectors++;
      if (DIGIT_OUT !== e.dout || DIGIT_EN_N !== e.en || PENDING !== e.pend || FRAME_TICK !== e.ft) begin
        miscompares++;
        $display("FAIL vec%0d t=%0d: dout=%h en=%b pend=%b ft=%b, required dout=%h en=%b pend=%b ft=%b",
                 vectors, $time, DIGIT_OUT, DIGIT_EN_N, PENDING, FRAME_TICK,
                 e.dout, e.en, e.pend, e.ft);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int r;
    logic [3:0] bl;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 16'h0, 1'b0, 4'h0);
    idx_ins: begin
      idle(20, 1'b0);
    end
    step(1'b1, 1'b1, 16'h1A2F, 1'b0, 4'h0);
    idle(2 * DIV * N, 1'b0);

    step(1'b1, 1'b1, 16'h0030, 1'b1, 4'h0);
    idle(2 * DIV * N, 1'b1);
    step(1'b1, 1'b1, 16'h0000, 1'b1, 4'h0);
    idle(2 * DIV * N, 1'b1);

    to_commit_edge(1'b0);
    idle(2, 1'b0);
    step(1'b1, 1'b1, 16'h1111, 1'b0, 4'h0);
    step(1'b1, 1'b1, 16'h2222, 1'b0, 4'h0);
    idle(2 * DIV * N, 1'b0);

    idle(3, 1'b0);
    step(1'b1, 1'b1, 16'h4444, 1'b0, 4'h0);
    while (((t + 1) % (DIV * N)) != 0) step(1'b1, 1'b0, 16'h0, 1'b0, 4'h0);
    step(1'b1, 1'b1, 16'h3333, 1'b0, 4'h0);
    idle(DIV * N + 2, 1'b0);

    step(1'b1, 1'b1, 16'h5678, 1'b0, 4'h0);
    while ((t % (DIV * N)) != 2 * DIV + 2) step(1'b1, 1'b0, 16'h0, 1'b0, 4'h0);
    step(1'b0, 1'b0, 16'h0, 1'b0, 4'h0);
    idle(DIV * N + 3, 1'b0);

    step(1'b1, 1'b0, 16'h0, 1'b0, 4'b0101);
    idle(DIV * N, 1'b0);

    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 199));
      bl = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
      step((r != 0), ($urandom_range(0, 7) == 0), 16'($urandom),
           1'($urandom), bl);
    end

    @(negedge CLK);
    @(negedge CLK);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
